l2_write_buffer: RTL and testbench

Write-back buffer between the cache arbiter (upstream) and the L2 cache (downstream). It absorbs dirty-line writes from the arbiter and acknowledges them in 1 cycle. It drains those writes to L2 when the downstream port is idle. Reads that hit a buffered line are served from the buffer; read misses go to L2 and take priority over drains that have not yet started.

---
 rtl/l2_write_buffer_pkg.sv | 20 ++
 rtl/l2_write_buffer_control.sv | 94 +++++++++
 rtl/l2_write_buffer.sv | 155 +++++++++++++++
 tb/tb_l2_write_buffer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_write_buffer_pkg.sv
// Shared LC-3b memory-side types for the L2 write-back buffer.
// Line tag width follows the default 16-byte (128-bit) line.
package lc3b_types;

    localparam int WB_LINE_OFFSET = 4;

    typedef logic [15:0]               lc3b_word;
    typedef logic [127:0]              lc3b_cache_line;
    typedef logic [15:WB_LINE_OFFSET]  lc3b_line_tag;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_HIT_ACK,
        RD_MISS,
        RD_ACK,
        DRAIN
    } wb_state_t;

endpackage

// File: rtl/l2_write_buffer_control.sv
// Sequencer for the write-back buffer: accepts, hits, misses and drains.
// All port-facing enables are decoded from the state register alone.
module l2_write_buffer_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr_req,
    input  logic rd_req,
    input  logic hit,
    input  logic full,
    input  logic empty,
    input  logic mem_resp,
    output logic push,
    output logic coalesce,
    output logic pop,
    output logic latch_hit,
    output logic latch_miss,
    output logic miss_start,
    output logic rd_en,
    output logic wr_en,
    output logic resp,
    output logic rdata_en
);

    wb_state_t state_q;
    wb_state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        coalesce   = 1'b0;
        pop        = 1'b0;
        latch_hit  = 1'b0;
        latch_miss = 1'b0;
        miss_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Writes outrank reads; reads outrank a drain not yet begun.
                if (wr_req) begin
                    if (hit) begin
                        coalesce = 1'b1;
                        state_d  = WR_ACK;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = WR_ACK;
                    end else if (!empty) begin
                        state_d = DRAIN;
                    end
                end else if (rd_req) begin
                    if (hit) begin
                        latch_hit = 1'b1;
                        state_d   = RD_HIT_ACK;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = RD_MISS;
                    end
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            WR_ACK:     state_d = IDLE;
            RD_HIT_ACK: state_d = IDLE;
            RD_MISS: begin
                if (mem_resp) begin
                    latch_miss = 1'b1;
                    state_d    = RD_ACK;
                end
            end
            RD_ACK:     state_d = IDLE;
            DRAIN: begin
                if (mem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    assign rd_en    = (state_q == RD_MISS);
    assign wr_en    = (state_q == DRAIN);
    assign rdata_en = (state_q == RD_HIT_ACK) || (state_q == RD_ACK);
    assign resp     = rdata_en || (state_q == WR_ACK);

endmodule

// File: rtl/l2_write_buffer.sv
// Write-back buffer between the cache arbiter and L2: absorbs dirty lines,
// serves read hits locally and drains to L2 when the downstream port is free.
module l2_write_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH       = 4,
    parameter int LINE_OFFSET = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  arb_mem_address,
    input  logic         arb_mem_read,
    input  logic         arb_mem_write,
    input  logic [127:0] arb_mem_wdata,
    output logic [127:0] arb_mem_rdata,
    output logic         arb_mem_resp,
    output logic [15:0]  mem_address,
    output logic         mem_read,
    output logic         mem_write,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_resp,
    output logic         buf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = 16 - LINE_OFFSET;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0] tag_q [DEPTH];
    lc3b_cache_line   line_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [TAG_W-1:0] miss_tag_q;
    lc3b_cache_line   rdata_q;

    logic [TAG_W-1:0] req_tag;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] hit_idx;
    logic             hit;
    logic             full;
    logic             empty;

    logic push, coalesce, pop;
    logic latch_hit, latch_miss, miss_start;
    logic rd_en, wr_en, resp, rdata_en;

    logic unused_offset;
    assign unused_offset = ^arb_mem_address[LINE_OFFSET-1:0];

    assign req_tag = arb_mem_address[15:LINE_OFFSET];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

    // Coalescing keeps tags unique, so at most one bit of match is set.
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == req_tag);
            if (match[i]) begin
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign hit = |match;

    l2_write_buffer_control u_control (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (arb_mem_write),
        .rd_req     (arb_mem_read),
        .hit        (hit),
        .full       (full),
        .empty      (empty),
        .mem_resp   (mem_resp),
        .push       (push),
        .coalesce   (coalesce),
        .pop        (pop),
        .latch_hit  (latch_hit),
        .latch_miss (latch_miss),
        .miss_start (miss_start),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .resp       (resp),
        .rdata_en   (rdata_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
                count_q         <= count_q + 1'b1;
            end else if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
                count_q         <= count_q - 1'b1;
            end
        end
    end

    // Payload needs no reset: valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= req_tag;
            line_q[tail_q] <= arb_mem_wdata;
        end else if (coalesce) begin
            line_q[hit_idx] <= arb_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_tag_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (miss_start) begin
                miss_tag_q <= req_tag;
            end
            if (latch_hit) begin
                rdata_q <= line_q[hit_idx];
            end else if (latch_miss) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        if (rd_en) begin
            mem_address = {miss_tag_q, {LINE_OFFSET{1'b0}}};
        end else if (wr_en) begin
            mem_address = {tag_q[head_q], {LINE_OFFSET{1'b0}}};
            mem_wdata   = line_q[head_q];
        end
    end

    assign mem_read      = rd_en;
    assign mem_write     = wr_en;
    assign arb_mem_resp  = resp;
    assign arb_mem_rdata = rdata_en ? rdata_q : '0;
    assign buf_empty     = empty;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Bench for l2_write_buffer: directed vectors, corner sequences and a
// randomized run checked against a line-level memory model with an L2 stub.
module tb_l2_write_buffer;

    logic         clk;
    logic         reset;
    logic [15:0]  arb_mem_address;
    logic         arb_mem_read;
    logic         arb_mem_write;
    logic [127:0] arb_mem_wdata;
    logic [127:0] arb_mem_rdata;
    logic         arb_mem_resp;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         buf_empty;

    l2_write_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .arb_mem_address (arb_mem_address),
        .arb_mem_read    (arb_mem_read),
        .arb_mem_write   (arb_mem_write),
        .arb_mem_wdata   (arb_mem_wdata),
        .arb_mem_rdata   (arb_mem_rdata),
        .arb_mem_resp    (arb_mem_resp),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .buf_empty       (buf_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [127:0] LA = {4{32'hAAAA_0001}};
    localparam logic [127:0] LB = {4{32'hBBBB_0002}};
    localparam logic [127:0] LC = {4{32'hCCCC_0003}};
    localparam logic [127:0] LD = {4{32'hDDDD_0004}};
    localparam logic [127:0] LE = {4{32'hEEEE_0005}};
    localparam logic [127:0] LF = {4{32'hFFFF_0006}};
    localparam logic [127:0] LG = {4{32'h1111_0007}};
    localparam logic [127:0] LH = {4{32'h2222_0008}};

    int checks = 0;
    int errors = 0;

    // L2 stub: responds only while l2_served < l2_allow.
    logic [127:0] l2_mem  [logic [11:0]];
    int           l2_wcnt [logic [11:0]];
    int           l2_served   = 0;
    int           l2_allow    = 0;
    int           l2_wr_total = 0;
    int           l2_delay    = 0;
    int           dcnt        = 0;
    bit           l2_rand     = 1'b0;
    logic [15:0]  last_wr_addr = '0;

    function automatic logic [127:0] l2_init(input logic [11:0] t);
        return {{10{t}}, 8'h5A};
    endfunction

    function automatic logic [127:0] l2_peek(input logic [11:0] t);
        if (l2_mem.exists(t)) return l2_mem[t];
        return l2_init(t);
    endfunction

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_resp = 1'b0;
            if (reset || !(mem_read || mem_write)) begin
                dcnt = 0;
            end else if (l2_served < l2_allow) begin
                if (dcnt >= l2_delay) begin
                    mem_resp = 1'b1;
                    l2_served++;
                    if (mem_write) begin
                        l2_mem[mem_address[15:4]] = mem_wdata;
                        if (l2_wcnt.exists(mem_address[15:4]))
                            l2_wcnt[mem_address[15:4]]++;
                        else
                            l2_wcnt[mem_address[15:4]] = 1;
                        l2_wr_total++;
                        last_wr_addr = mem_address;
                    end else begin
                        mem_rdata = l2_peek(mem_address[15:4]);
                    end
                    dcnt     = 0;
                    l2_delay = l2_rand ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit saw_rd;
    bit saw_wr;

    task automatic do_req(input bit wr, input logic [15:0] addr,
                          input logic [127:0] data, output logic [127:0] rd,
                          output int lat);
        bit ok;
        arb_mem_address = addr;
        arb_mem_wdata   = data;
        arb_mem_write   = wr;
        arb_mem_read    = !wr;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        ok  = 1'b0;
        lat = 0;
        rd  = '0;
        while (!ok && lat < 300) begin
            @(negedge clk);
            lat++;
            if (mem_read)  saw_rd = 1'b1;
            if (mem_write) saw_wr = 1'b1;
            if (arb_mem_resp) begin
                ok = 1'b1;
                rd = arb_mem_rdata;
            end
        end
        arb_mem_write = 1'b0;
        arb_mem_read  = 1'b0;
        chk("req_resp_seen", 128'(ok), 128'(1));
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!buf_empty && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(buf_empty), 128'(1));
    endtask

    task automatic wait_mem_write(input string name);
        int n = 0;
        while (!mem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(mem_write), 128'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_resp"},  128'(arb_mem_resp), 128'(0));
        chk({pfx, "_rdata"}, arb_mem_rdata, '0);
        chk({pfx, "_mrd"},   128'(mem_read), 128'(0));
        chk({pfx, "_mwr"},   128'(mem_write), 128'(0));
        chk({pfx, "_maddr"}, 128'(mem_address), 128'(0));
        chk({pfx, "_mwd"},   mem_wdata, '0);
        chk({pfx, "_empty"}, 128'(buf_empty), 128'(1));
    endtask

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t         tbl [12];
    logic [127:0] rd;
    logic [127:0] expd;
    logic [127:0] d;
    logic [15:0]  a;
    logic [11:0]  t;
    logic [127:0] ref_mem [logic [11:0]];
    int           lat;
    int           n;
    int           base;
    int           op;
    bit           got;

    initial begin
        tbl[0]  = '{1'b1, 16'h1230, LA, '0, 1};
        tbl[1]  = '{1'b0, 16'h1238, '0, LA, 2};
        tbl[2]  = '{1'b1, 16'h2000, LB, '0, 2};
        tbl[3]  = '{1'b1, 16'h2004, LC, '0, 2};
        tbl[4]  = '{1'b0, 16'h200F, '0, LC, 2};
        tbl[5]  = '{1'b1, 16'h3000, LD, '0, 2};
        tbl[6]  = '{1'b1, 16'h1234, LE, '0, 2};
        tbl[7]  = '{1'b0, 16'h1230, '0, LE, 2};
        tbl[8]  = '{1'b1, 16'h4000, LF, '0, 2};
        tbl[9]  = '{1'b0, 16'h4008, '0, LF, 2};
        tbl[10] = '{1'b1, 16'h3003, LG, '0, 2};
        tbl[11] = '{1'b0, 16'h3000, '0, LG, 2};

        reset           = 1'b1;
        arb_mem_address = '0;
        arb_mem_read    = 1'b0;
        arb_mem_write   = 1'b0;
        arb_mem_wdata   = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Single write, then a drain once L2 is allowed to answer.
        do_req(1'b1, 16'h1230, LA, rd, lat);
        chk("t1_lat", 128'(lat), 128'(1));
        chk("t1_not_empty", 128'(buf_empty), 128'(0));
        wait_mem_write("t1_drain_start");
        chk("t1_drain_addr", 128'(mem_address), 128'(16'h1230));
        chk("t1_drain_data", mem_wdata, LA);
        @(posedge clk);
        #1 l2_allow = l2_served + 1;
        wait_empty("t1_empty");
        chk("t1_l2_line", l2_peek(12'h123), LA);

        // Back-to-back vectors with L2 stalled: no drain may start.
        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i].wr, tbl[i].addr, tbl[i].data, rd, lat);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
            if (!tbl[i].wr)
                chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
            chk($sformatf("vec%0d_l2_quiet", i), 128'({saw_rd, saw_wr}), 128'(0));
            chk($sformatf("vec%0d_not_empty", i), 128'(buf_empty), 128'(0));
        end

        // Fifth distinct line while full: stalls behind a drain.
        arb_mem_address = 16'h5000;
        arb_mem_wdata   = LH;
        arb_mem_write   = 1'b1;
        got = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (arb_mem_resp) got = 1'b1;
        end
        chk("t4_no_resp", 128'(got), 128'(0));
        chk("t4_drain_wr", 128'(mem_write), 128'(1));
        chk("t4_drain_addr", 128'(mem_address), 128'(16'h1230));
        chk("t4_drain_data", mem_wdata, LE);
        @(posedge clk);
        #1 l2_allow = l2_served + 1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = arb_mem_resp;
        end
        arb_mem_write = 1'b0;
        chk("t4_resp_delay", 128'(n), 128'(3));
        base     = l2_wr_total;
        l2_allow = 1 << 30;
        wait_empty("t4_empty");
        chk("t4_drain_count", 128'(l2_wr_total - base), 128'(4));
        chk("t4_l2_200", l2_peek(12'h200), LC);
        chk("t4_l2_300", l2_peek(12'h300), LG);
        chk("t4_l2_400", l2_peek(12'h400), LF);
        chk("t4_l2_500", l2_peek(12'h500), LH);
        chk("t4_l2_123", l2_peek(12'h123), LE);
        chk("t3_single_wr", 128'(l2_wcnt.exists(12'h200) ? l2_wcnt[12'h200] : 0), 128'(1));

        // Read miss overtakes a pending drain.
        pulse_reset();
        do_req(1'b1, 16'h1230, LA, rd, lat);
        base            = l2_wr_total;
        arb_mem_address = 16'h4000;
        arb_mem_read    = 1'b1;
        n      = 0;
        saw_wr = 1'b0;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_write) saw_wr = 1'b1;
        end
        chk("t5_miss_issued", 128'(mem_read), 128'(1));
        chk("t5_miss_addr", 128'(mem_address), 128'(16'h4000));
        chk("t5_no_drain_first", 128'({saw_wr, mem_write}), 128'(0));
        chk("t5_no_l2_wr", 128'(l2_wr_total - base), 128'(0));
        @(negedge clk);
        chk("t5_resp", 128'(arb_mem_resp), 128'(1));
        chk("t5_rdata", arb_mem_rdata, LF);
        arb_mem_read = 1'b0;
        wait_empty("t5_empty");
        chk("t5_drain_addr", 128'(last_wr_addr), 128'(16'h1230));
        chk("t5_l2_123", l2_peek(12'h123), LA);

        // Reset in the middle of a stalled drain discards the buffer.
        pulse_reset();
        l2_allow = l2_served;
        do_req(1'b1, 16'h6000, LB, rd, lat);
        do_req(1'b1, 16'h7000, LC, rd, lat);
        do_req(1'b1, 16'h8000, LD, rd, lat);
        wait_mem_write("t6_drain_start");
        repeat (2) @(negedge clk);
        chk("t6_in_drain", 128'(mem_write), 128'(1));
        chk("t6_drain_addr", 128'(mem_address), 128'(16'h6000));
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t6_after_reset");
        reset    = 1'b0;
        l2_allow = 1 << 30;
        do_req(1'b0, 16'h7004, '0, rd, lat);
        chk("t6_miss", 128'(saw_rd), 128'(1));
        chk("t6_rdata", rd, l2_init(12'h700));

        // Randomized traffic over six lines against a line-level model.
        pulse_reset();
        l2_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            op = int'($urandom_range(0, 2));
            t  = 12'hA00 + 12'($urandom_range(0, 5));
            a  = {t, 4'($urandom_range(0, 15))};
            if (op == 0) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                ref_mem[t] = d;
                do_req(1'b1, a, d, rd, lat);
            end else if (op == 1) begin
                expd = ref_mem.exists(t) ? ref_mem[t] : l2_init(t);
                do_req(1'b0, a, '0, rd, lat);
                chk($sformatf("rnd%0d_rdata_%h", k, a), rd, expd);
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        wait_empty("rnd_empty");
        foreach (ref_mem[tt])
            chk($sformatf("rnd_l2_%h", tt), l2_peek(tt), ref_mem[tt]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
